// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: default widths and FSM states.
package fetch_pkg;
    localparam int ADDR_W_DEF = 8;
    localparam int INST_W_DEF = 9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// Fetch controller bus: control from decode/execute, ROM address/data, and latched instruction.
interface inst_fetch_ctrl_if
    import fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int INST_W = INST_W_DEF
);
    logic              Start;
    logic [ADDR_W-1:0] StartAddr;
    logic              Stall;
    logic              BranchTaken;
    logic              BranchRel;
    logic [ADDR_W-1:0] BranchTarget;
    logic              Halt;
    logic [ADDR_W-1:0] Address;
    logic [INST_W-1:0] Instruction;
    logic [INST_W-1:0] InstOut;
    logic [ADDR_W-1:0] InstPC;
    logic              InstValid;
    logic              Running;
    logic              Done;

    modport master (
        input  Start, StartAddr, Stall, BranchTaken, BranchRel, BranchTarget, Halt, Instruction,
        output Address, InstOut, InstPC, InstValid, Running, Done
    );

    modport slave (
        output Start, StartAddr, Stall, BranchTaken, BranchRel, BranchTarget, Halt, Instruction,
        input  Address, InstOut, InstPC, InstValid, Running, Done
    );
endinterface

// File: rtl/inst_fetch_ctrl_pc_next.sv
// Combinational next-PC select: start > branch > increment > hold, all modulo 2**ADDR_W.
module pc_next
    import fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] inst_pc,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              start_go,
    input  logic              branch_go,
    input  logic              branch_rel,
    input  logic              seq_go,
    output logic [ADDR_W-1:0] pc_nxt
);
    always_comb begin
        pc_nxt = pc;
        if (start_go)
            pc_nxt = start_addr;
        // Offset is already ADDR_W wide, so a truncating add equals sign-extend-then-wrap.
        else if (branch_go)
            pc_nxt = branch_rel ? inst_pc + branch_target : branch_target;
        else if (seq_go)
            pc_nxt = pc + ADDR_W'(1);
    end
endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: PC register, IDLE/RUN/HALTED FSM and registered instruction latch.
module inst_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int INST_W = INST_W_DEF
) (
    input  logic              CLK,
    input  logic              Reset_n,
    inst_fetch_ctrl_if.master bus
);
    fetch_state_t      state;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic [INST_W-1:0] inst_out;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_valid, running, done;
    logic              run, start_go, halt_go, branch_go, seq_go;

    // Halt and branch only act on a live instruction; stall masks branch but not halt.
    assign run       = (state == RUN);
    assign start_go  = !run && bus.Start;
    assign halt_go   = run && bus.Halt && inst_valid;
    assign branch_go = run && !halt_go && !bus.Stall && bus.BranchTaken && inst_valid;
    assign seq_go    = run && !halt_go && !bus.Stall && !branch_go;

    pc_next #(.ADDR_W(ADDR_W)) u_pc_next (
        .pc            (pc),
        .inst_pc       (inst_pc),
        .start_addr    (bus.StartAddr),
        .branch_target (bus.BranchTarget),
        .start_go      (start_go),
        .branch_go     (branch_go),
        .branch_rel    (bus.BranchRel),
        .seq_go        (seq_go),
        .pc_nxt        (pc_nxt)
    );

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            pc         <= '0;
            inst_out   <= '0;
            inst_pc    <= '0;
            inst_valid <= 1'b0;
            running    <= 1'b0;
            done       <= 1'b0;
        end else begin
            pc <= pc_nxt;
            case (state)
                RUN: begin
                    if (halt_go) begin
                        state      <= HALTED;
                        inst_valid <= 1'b0;
                        running    <= 1'b0;
                        done       <= 1'b1;
                    end else if (branch_go) begin
                        // Word at the current PC is wrong-path; drop it.
                        inst_valid <= 1'b0;
                    end else if (seq_go) begin
                        inst_out   <= bus.Instruction;
                        inst_pc    <= pc;
                        inst_valid <= 1'b1;
                    end
                end
                default: begin
                    if (start_go) begin
                        state      <= RUN;
                        inst_valid <= 1'b0;
                        running    <= 1'b1;
                        done       <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.Address   = pc;
    assign bus.InstOut   = inst_out;
    assign bus.InstPC    = inst_pc;
    assign bus.InstValid = inst_valid;
    assign bus.Running   = running;
    assign bus.Done      = done;
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Scoreboard bench for inst_fetch_ctrl: per-cycle stimulus tables, expected state queued on drive.
module tb_inst_fetch_ctrl;
    typedef struct packed {
        logic       start;
        logic [7:0] saddr;
        logic       stall;
        logic       br;
        logic       rel;
        logic [7:0] tgt;
        logic       halt;
    } stim_t;

    typedef struct packed {
        logic       valid;
        logic [7:0] pc;
        logic [8:0] inst;
        logic [7:0] addr;
        logic       running;
        logic       done;
    } exp_t;

    logic       CLK = 1'b0;
    logic       Reset_n;
    logic [8:0] rom [256];
    exp_t       sb [$];
    int         n_chk  = 0;
    int         n_fail = 0;

    inst_fetch_ctrl_if #(.ADDR_W(8), .INST_W(9)) bus ();

    inst_fetch_ctrl #(.ADDR_W(8), .INST_W(9)) dut (
        .CLK     (CLK),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;
    assign bus.Instruction = rom[bus.Address];

    function automatic stim_t mk_stim(logic start, logic [7:0] saddr, logic stall, logic br,
                                      logic rel, logic [7:0] tgt, logic halt);
        return {start, saddr, stall, br, rel, tgt, halt};
    endfunction

    function automatic stim_t nop();
        return '0;
    endfunction

    // Fetched word is only meaningful while valid, so invalid entries carry zeros.
    function automatic exp_t mk_exp(logic v, logic [7:0] pc, logic [7:0] addr, logic r, logic d);
        return {v, (v ? pc : 8'h00), (v ? rom[pc] : 9'h000), addr, r, d};
    endfunction

    function automatic exp_t observe();
        return {bus.InstValid, (bus.InstValid ? bus.InstPC : 8'h00),
                (bus.InstValid ? bus.InstOut : 9'h000), bus.Address, bus.Running, bus.Done};
    endfunction

    task automatic drive(stim_t s);
        bus.Start        = s.start;
        bus.StartAddr    = s.saddr;
        bus.Stall        = s.stall;
        bus.BranchTaken  = s.br;
        bus.BranchRel    = s.rel;
        bus.BranchTarget = s.tgt;
        bus.Halt         = s.halt;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        logic [29:0] raw;
        drive(nop());
        Reset_n = 1'b0;
        #1;
        raw = {bus.InstValid, bus.InstPC, bus.InstOut, bus.Address, bus.Running, bus.Done};
        n_chk++;
        if (raw !== 30'h0) begin
            n_fail++;
            $display("FAIL reset_state: got %h want 0", raw);
        end
        tick();
        tick();
        Reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sb.push_back(mk_exp(0, 8'h00, 8'h00, 0, 0));
            tick();
            begin
                exp_t e, o;
                e = sb.pop_front();
                o = observe();
                n_chk++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL idle_no_fetch[%0d]: got %h want %h", i, o, e);
                end
            end
        end
    endtask

    task automatic test_start();
        stim_t st [4];
        exp_t  ex [4];
        st[0] = mk_stim(1, 8'h10, 0, 0, 0, 8'h00, 0); ex[0] = mk_exp(0, 8'h00, 8'h10, 1, 0);
        st[1] = nop();                                ex[1] = mk_exp(1, 8'h10, 8'h11, 1, 0);
        st[2] = mk_stim(1, 8'h80, 0, 0, 0, 8'h00, 0); ex[2] = mk_exp(1, 8'h11, 8'h12, 1, 0);
        st[3] = nop();                                ex[3] = mk_exp(1, 8'h12, 8'h13, 1, 0);
        for (int i = 0; i < 4; i++) begin
            exp_t e, o;
            drive(st[i]);
            sb.push_back(ex[i]);
            tick();
            e = sb.pop_front();
            o = observe();
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL start[%0d]: got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_branch_abs();
        stim_t st [3];
        exp_t  ex [3];
        st[0] = mk_stim(0, 8'h00, 0, 1, 0, 8'h40, 0); ex[0] = mk_exp(0, 8'h00, 8'h40, 1, 0);
        st[1] = nop();                                ex[1] = mk_exp(1, 8'h40, 8'h41, 1, 0);
        st[2] = nop();                                ex[2] = mk_exp(1, 8'h41, 8'h42, 1, 0);
        for (int i = 0; i < 3; i++) begin
            exp_t e, o;
            drive(st[i]);
            sb.push_back(ex[i]);
            tick();
            e = sb.pop_front();
            o = observe();
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL branch_abs[%0d]: got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_branch_rel_wrap();
        stim_t st [7];
        exp_t  ex [7];
        st[0] = mk_stim(0, 8'h00, 0, 1, 0, 8'h02, 0); ex[0] = mk_exp(0, 8'h00, 8'h02, 1, 0);
        st[1] = nop();                                ex[1] = mk_exp(1, 8'h02, 8'h03, 1, 0);
        st[2] = mk_stim(0, 8'h00, 0, 1, 1, 8'hFC, 0); ex[2] = mk_exp(0, 8'h00, 8'hFE, 1, 0);
        st[3] = nop();                                ex[3] = mk_exp(1, 8'hFE, 8'hFF, 1, 0);
        st[4] = nop();                                ex[4] = mk_exp(1, 8'hFF, 8'h00, 1, 0);
        st[5] = nop();                                ex[5] = mk_exp(1, 8'h00, 8'h01, 1, 0);
        st[6] = nop();                                ex[6] = mk_exp(1, 8'h01, 8'h02, 1, 0);
        for (int i = 0; i < 7; i++) begin
            exp_t e, o;
            drive(st[i]);
            sb.push_back(ex[i]);
            tick();
            e = sb.pop_front();
            o = observe();
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL branch_rel[%0d]: got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_stall();
        stim_t st [4];
        exp_t  ex [4];
        for (int i = 0; i < 3; i++) begin
            st[i] = mk_stim(0, 8'h00, 1, 1, 0, 8'h80, 0);
            ex[i] = mk_exp(1, 8'h01, 8'h02, 1, 0);
        end
        st[3] = nop(); ex[3] = mk_exp(1, 8'h02, 8'h03, 1, 0);
        for (int i = 0; i < 4; i++) begin
            exp_t e, o;
            drive(st[i]);
            sb.push_back(ex[i]);
            tick();
            e = sb.pop_front();
            o = observe();
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL stall[%0d]: got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_halt_restart();
        stim_t st [7];
        exp_t  ex [7];
        st[0] = mk_stim(0, 8'h00, 0, 1, 0, 8'h20, 0); ex[0] = mk_exp(0, 8'h00, 8'h20, 1, 0);
        st[1] = nop();                                ex[1] = mk_exp(1, 8'h20, 8'h21, 1, 0);
        st[2] = mk_stim(0, 8'h00, 1, 0, 0, 8'h00, 1); ex[2] = mk_exp(0, 8'h00, 8'h21, 0, 1);
        st[3] = nop();                                ex[3] = mk_exp(0, 8'h00, 8'h21, 0, 1);
        st[4] = mk_stim(0, 8'h00, 0, 1, 0, 8'h50, 1); ex[4] = mk_exp(0, 8'h00, 8'h21, 0, 1);
        st[5] = mk_stim(1, 8'h00, 0, 0, 0, 8'h00, 0); ex[5] = mk_exp(0, 8'h00, 8'h00, 1, 0);
        st[6] = nop();                                ex[6] = mk_exp(1, 8'h00, 8'h01, 1, 0);
        for (int i = 0; i < 7; i++) begin
            exp_t e, o;
            drive(st[i]);
            sb.push_back(ex[i]);
            tick();
            e = sb.pop_front();
            o = observe();
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL halt[%0d]: got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        logic [29:0] raw;
        exp_t        e, o;
        drive(mk_stim(0, 8'h00, 0, 1, 0, 8'h33, 0));
        sb.push_back(mk_exp(0, 8'h00, 8'h33, 1, 0));
        tick();
        e = sb.pop_front();
        o = observe();
        n_chk++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL pre_reset_pc: got %h want %h", o, e);
        end
        drive(nop());
        #1;
        Reset_n = 1'b0;
        #1;
        raw = {bus.InstValid, bus.InstPC, bus.InstOut, bus.Address, bus.Running, bus.Done};
        n_chk++;
        if (raw !== 30'h0) begin
            n_fail++;
            $display("FAIL reset_mid_run: got %h want 0", raw);
        end
        #1;
        Reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(mk_exp(0, 8'h00, 8'h00, 0, 0));
            tick();
            e = sb.pop_front();
            o = observe();
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL post_reset_idle[%0d]: got %h want %h", i, o, e);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++)
            rom[i] = 9'((i * 37 + 5) % 512);
        test_reset();
        test_start();
        test_branch_abs();
        test_branch_rel_wrap();
        test_stall();
        test_halt_restart();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
